life_row_engine: RTL and testbench
==================================

Name: life_row_engine

Overview:
- Streaming Game-of-Life next-generation engine for an N-bit-wide cell grid, processed one row per beat.
- Holds a 3-row line buffer and forms the 3x3 neighbour count (0..8) for every cell of the middle row. The count is the three-row adder sum: the above and below rows use the full 3-cell window, the middle row uses the 2 side cells only.
- Applies a programmable birth/survive rule and emits the new row on a valid/ready stream.
- Parametrised, pipelined successor to the fixed 32-bit combinational three-row neighbour adder. Sits between the grid row memory reader and the writer.

Parameters:
- WIDTH, 32, cells per row (>=3).
- BIRTH_MASK, 9'b000001000, bit n set: a dead cell with n neighbours becomes alive.
- SURVIVE_MASK, 9'b000001100, bit n set: a live cell with n neighbours stays alive.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_row  in  WIDTH  current-generation row; bit 0 = column 0
- in_sof  in  1  first row of frame, qualified by in_valid
- in_eof  in  1  last row of frame, qualified by in_valid
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts beat
- out_row  out  WIDTH  next-generation row
- out_pop  out  $clog2(WIDTH+1)  number of live cells in out_row
- out_eof  out  1  out_row is last row of frame
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- frame_err  out  1  one-cycle pulse: protocol violation detected

Behaviour:
- Reset (async, any state): state=IDLE; line buffer rows cleared to 0; out_valid=0, out_row=0, out_pop=0, out_eof=0, frame_err=0. Any partially received frame is discarded; no output for it after reset.
- Beat transfer occurs when valid && ready are both high at a rising edge. Output register is single entry; out_row, out_pop and out_eof stay stable while out_valid && !out_ready.
- Free output slot means !out_valid || out_ready.
- in_ready = free output slot, in states IDLE/FILL/STREAM. in_ready = 0 in FLUSH.
- Rows outside the frame (above row 0, below the last row) are all zeros. Columns -1 and WIDTH are 0 (edge behaviour is changed by the optional feature).
- Neighbour count: 4-bit unsigned per cell, range 0..8, no saturation needed.
- New cell value = cell ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt].
- State FSM; buffer roles are above=A, mid=M, below=B:
  - IDLE:
    - Accept with in_sof=0: drop the beat, pulse frame_err, stay in IDLE.
    - Accept with in_sof && in_eof: A=0, M=in_row, B=0, go to FLUSH (single-row frame).
    - Accept with in_sof: A=0, M=in_row, go to FILL.
  - FILL / STREAM, accept beat: B=in_row, compute row M, load output register (out_eof=0), then shift A<=M, M<=in_row. FILL moves to STREAM.
    - If in_eof on that beat: go to FLUSH.
  - FLUSH: when the output slot is free, compute row M with B=0, load output with out_eof=1, go to IDLE.
  - in_sof inside FILL/STREAM (frame not ended): pulse frame_err, discard the buffered rows, restart as if from IDLE with this beat. No output is produced for the aborted row in M.
- Latency: output row k is registered on the edge that accepts input row k+1. The last row is registered on the first free-slot cycle in FLUSH.
- Throughput: 1 row/cycle sustained, plus 1 bubble per frame (FLUSH).
- out_pop is computed combinationally from the next out_row and registered with it.

Optional Feature:
- Macro: LIFE_TOROIDAL_EN.
- Defined: horizontal wrap. Column -1 reads column WIDTH-1 and column WIDTH reads column 0, in all three rows. Vertical edges are still zero.
- Undefined: columns outside 0..WIDTH-1 are 0.
- Ports, latency and handshake are identical either way.

Test Plan:
- WIDTH=8, default masks, no backpressure.
  - Rows 00,08,08,08,00 (sof on first, eof on last) -> out_row 00,00,1C,00,00.
  - out_pop 0,0,3,0,0; out_eof only on 5th output.
- Still-life block: 00,06,06,00 -> 00,06,06,00. out_pop 0,2,2,0.
- Single-row frame, sof=eof=1, in_row=FF:
  - Macro off -> out_row 7E, out_pop 6, out_eof 1.
  - Macro on -> out_row FF, out_pop 8.
- Backpressure on the blinker stream: hold out_ready=0 for 5 cycles after the first out_valid.
  - in_ready=0 throughout the hold; out_row stays 00 stable.
  - After release the sequence completes unchanged.
- Protocol errors:
  - Beat without sof in IDLE -> frame_err pulse, no output.
  - sof after 2 rows of a frame -> frame_err pulse, old frame dropped, new frame output correctly.
- Reset asserted mid-frame (after 2 of 5 rows):
  - Immediately out_valid=0, in_ready=1.
  - A following full blinker frame gives 00,00,1C,00,00.

Source files
------------

// File: rtl/life_row_engine_if.sv
// Row stream bundle for life_row_engine: input row stream, output row stream and the error pulse.
// The engine uses the slave modport; the row reader/writer side uses master.
interface life_row_engine_if #(
    parameter int WIDTH = 32
);
    localparam int POP_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] in_row;
    logic             in_sof;
    logic             in_eof;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out_row;
    logic [POP_W-1:0] out_pop;
    logic             out_eof;
    logic             out_valid;
    logic             out_ready;

    logic             frame_err;

    modport master (
        output in_row, in_sof, in_eof, in_valid, out_ready,
        input  in_ready, out_row, out_pop, out_eof, out_valid, frame_err
    );

    modport slave (
        input  in_row, in_sof, in_eof, in_valid, out_ready,
        output in_ready, out_row, out_pop, out_eof, out_valid, frame_err
    );
endinterface

// File: rtl/life_row_engine.sv
// Streaming Game-of-Life next-generation engine, one WIDTH-cell row per beat.
// Define LIFE_TOROIDAL_EN for horizontal wrap-around; otherwise columns outside the row read as dead.
module life_row_engine #(
    parameter int         WIDTH        = 32,
    parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
    parameter logic [8:0] SURVIVE_MASK = 9'b000001100
) (
    input  logic                   clk,
    input  logic                   reset,
    life_row_engine_if.slave       bus
);
    localparam int POP_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

    state_t           state;
    logic [WIDTH-1:0] row_a;      // row above the one being computed
    logic [WIDTH-1:0] row_m;      // row being computed
    logic [WIDTH-1:0] row_b;      // row below: the incoming beat, or zeros past the frame end
    logic [WIDTH-1:0] next_row;
    logic [POP_W-1:0] next_pop;
    logic             slot_free;
    logic             accept;

    function automatic logic [WIDTH-1:0] next_gen(
        input logic [WIDTH-1:0] up,
        input logic [WIDTH-1:0] mid,
        input logic [WIDTH-1:0] dn
    );
        logic [WIDTH+1:0] pu, pm, pd;
        logic [3:0]       cnt;
        logic [WIDTH-1:0] res;
        // Padded rows: index 0 is column -1, index WIDTH+1 is column WIDTH.
`ifdef LIFE_TOROIDAL_EN
        pu = {up[0],  up,  up[WIDTH-1]};
        pm = {mid[0], mid, mid[WIDTH-1]};
        pd = {dn[0],  dn,  dn[WIDTH-1]};
`else
        pu = {1'b0, up,  1'b0};
        pm = {1'b0, mid, 1'b0};
        pd = {1'b0, dn,  1'b0};
`endif
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = 4'(pu[i]) + 4'(pu[i+1]) + 4'(pu[i+2])
                + 4'(pm[i])                + 4'(pm[i+2])
                + 4'(pd[i]) + 4'(pd[i+1]) + 4'(pd[i+2]);
            res[i] = pm[i+1] ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt];
        end
        return res;
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] r);
        logic [POP_W-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            p = p + POP_W'(r[i]);
        end
        return p;
    endfunction

    assign slot_free    = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = slot_free && (state != FLUSH);
    assign accept       = bus.in_valid && bus.in_ready;
    assign row_b        = (state == FLUSH) ? '0 : bus.in_row;
    assign next_row     = next_gen(row_a, row_m, row_b);
    assign next_pop     = popcount(next_row);

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            row_a         <= '0;
            row_m         <= '0;
            bus.out_row   <= '0;
            bus.out_pop   <= '0;
            bus.out_eof   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.frame_err <= 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!bus.in_sof) begin
                            bus.frame_err <= 1'b1;
                        end else begin
                            row_a <= '0;
                            row_m <= bus.in_row;
                            state <= bus.in_eof ? FLUSH : FILL;
                        end
                    end
                end

                FILL, STREAM: begin
                    if (accept) begin
                        if (bus.in_sof) begin
                            // Restart on the new frame; the aborted middle row is never emitted.
                            bus.frame_err <= 1'b1;
                            row_a         <= '0;
                            row_m         <= bus.in_row;
                            state         <= bus.in_eof ? FLUSH : FILL;
                        end else begin
                            bus.out_row   <= next_row;
                            bus.out_pop   <= next_pop;
                            bus.out_eof   <= 1'b0;
                            bus.out_valid <= 1'b1;
                            row_a         <= row_m;
                            row_m         <= bus.in_row;
                            state         <= bus.in_eof ? FLUSH : STREAM;
                        end
                    end
                end

                FLUSH: begin
                    if (slot_free) begin
                        bus.out_row   <= next_row;
                        bus.out_pop   <= next_pop;
                        bus.out_eof   <= 1'b1;
                        bus.out_valid <= 1'b1;
                        row_a         <= '0;
                        row_m         <= '0;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_life_row_engine.sv
// Self-checking bench for life_row_engine (WIDTH=8, default B3/S23 masks).
// A neighbour-counting grid model predicts every transferred output row; directed frames pin literal values.
module tb_life_row_engine;
    localparam int W  = 8;
    localparam int PW = $clog2(W + 1);

    typedef struct {
        logic [W-1:0] row;
        logic         eof;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    life_row_engine_if #(.WIDTH(W)) bus ();

    life_row_engine #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next generation of the middle row, counting the eight neighbours cell by cell.
    function automatic logic [W-1:0] model_gen(input logic [W-1:0] up, input logic [W-1:0] mid,
                                               input logic [W-1:0] dn);
        logic [W-1:0] g[3];
        logic [W-1:0] res;
        int           n;
        int           cc;
        g[0] = up;
        g[1] = mid;
        g[2] = dn;
        res  = '0;
        for (int c = 0; c < W; c++) begin
            n = 0;
            for (int dr = 0; dr < 3; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if (dr == 1 && dc == 0) continue;
                    cc = c + dc;
`ifdef LIFE_TOROIDAL_EN
                    cc = (cc + W) % W;
`else
                    if (cc < 0 || cc >= W) continue;
`endif
                    n += int'(g[dr][cc]);
                end
            end
            res[c] = mid[c] ? (n == 2 || n == 3) : (n == 3);
        end
        return res;
    endfunction

    // Scoreboard state
    exp_t         exp_q[$];
    logic [W-1:0] fr[$];
    bit           in_frame = 0;
    bit           err_pend = 0;
    bit           held = 0;
    logic [W-1:0] held_row;
    logic [PW-1:0] held_pop;
    logic         held_eof;
    logic [W-1:0] got_row[$];
    int           got_pop[$];
    bit           got_eof[$];
    bit           rand_bp = 0;

    // Compare process: samples 4 ns after each falling edge, i.e. just before the next rising edge.
    initial begin
        exp_t e;
        int   n;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                exp_q.delete();
                fr.delete();
                in_frame = 0;
                err_pend = 0;
                held     = 0;
                continue;
            end
            check("frame_err", 32'(bus.frame_err), 32'(err_pend));
            if (held) begin
                check("hold_valid", 32'(bus.out_valid), 1);
                check("hold_row", 32'(bus.out_row), 32'(held_row));
                check("hold_pop", 32'(bus.out_pop), 32'(held_pop));
                check("hold_eof", 32'(bus.out_eof), 32'(held_eof));
            end
            if (bus.out_valid && !bus.out_ready) begin
                check("in_ready_when_full", 32'(bus.in_ready), 0);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("output_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_row", 32'(bus.out_row), 32'(e.row));
                    check("out_pop", 32'(bus.out_pop), 32'($countones(e.row)));
                    check("out_eof", 32'(bus.out_eof), 32'(e.eof));
                end
                got_row.push_back(bus.out_row);
                got_pop.push_back(int'(bus.out_pop));
                got_eof.push_back(bus.out_eof);
            end
            held     = bus.out_valid && !bus.out_ready;
            held_row = bus.out_row;
            held_pop = bus.out_pop;
            held_eof = bus.out_eof;

            err_pend = 0;
            if (bus.in_valid && bus.in_ready) begin
                if (!bus.in_sof && !in_frame) begin
                    err_pend = 1;
                end else if (bus.in_sof) begin
                    err_pend = in_frame;
                    fr.delete();
                    fr.push_back(bus.in_row);
                    in_frame = 1;
                end else begin
                    fr.push_back(bus.in_row);
                    n = fr.size();
                    exp_q.push_back('{row: model_gen((n >= 3) ? fr[n-3] : '0, fr[n-2], fr[n-1]),
                                      eof: 1'b0});
                end
                if (in_frame && bus.in_eof) begin
                    n = fr.size();
                    exp_q.push_back('{row: model_gen((n >= 2) ? fr[n-2] : '0, fr[n-1], '0),
                                      eof: 1'b1});
                    fr.delete();
                    in_frame = 0;
                end
            end
        end
    end

    // Random downstream backpressure
    initial begin
        forever begin
            @(negedge clk);
            if (rand_bp) bus.out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Drives one beat starting at a falling edge; returns at the falling edge after it was accepted.
    task automatic send(input logic [W-1:0] row, input bit sof, input bit eof);
        bit ok;
        ok           = 0;
        bus.in_row   = row;
        bus.in_sof   = sof;
        bus.in_eof   = eof;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            #4;
            ok = bus.in_ready;
            @(negedge clk);
            if (ok) break;
        end
        if (!ok) check("send_timeout", 32'(ok), 1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eof   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] rows[$]);
        for (int i = 0; i < rows.size(); i++) begin
            send(rows[i], i == 0, i == rows.size() - 1);
        end
        idle(0);
    endtask

    task automatic wait_got(input int n);
        for (int t = 0; t < 500 && got_row.size() < n; t++) @(negedge clk);
        check("drain_count", 32'(got_row.size() >= n), 1);
    endtask

    task automatic expect_row(input int idx, input logic [W-1:0] row, input int pop, input bit eof);
        check("lit_present", 32'(idx < got_row.size()), 1);
        if (idx < got_row.size()) begin
            check("lit_row", 32'(got_row[idx]), 32'(row));
            check("lit_pop", 32'(got_pop[idx]), 32'(pop));
            check("lit_eof", 32'(got_eof[idx]), 32'(eof));
        end
    endtask

    task automatic expect_blinker(input int base);
        expect_row(base + 0, 8'h00, 0, 0);
        expect_row(base + 1, 8'h00, 0, 0);
        expect_row(base + 2, 8'h1C, 3, 0);
        expect_row(base + 3, 8'h00, 0, 0);
        expect_row(base + 4, 8'h00, 0, 1);
    endtask

    logic [W-1:0] blinker[$] = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h00};
    logic [W-1:0] block[$]   = '{8'h00, 8'h06, 8'h06, 8'h00};
    logic [W-1:0] full1[$]   = '{8'hFF};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d outputs", got_row.size());
        $fatal(1);
    end

    initial begin
        logic [W-1:0] rows[$];
        int           len;

        reset         = 1'b1;
        bus.in_row    = '0;
        bus.in_sof    = 1'b0;
        bus.in_eof    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_row", 32'(bus.out_row), 0);
        check("rst_out_pop", 32'(bus.out_pop), 0);
        check("rst_out_eof", 32'(bus.out_eof), 0);
        check("rst_frame_err", 32'(bus.frame_err), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        reset = 1'b0;
        @(negedge clk);

        // Pin the model against hand-computed generations.
        check("model_blinker_mid", 32'(model_gen(8'h08, 8'h08, 8'h08)), 32'h1C);
        check("model_block", 32'(model_gen(8'h06, 8'h06, 8'h00)), 32'h06);
`ifdef LIFE_TOROIDAL_EN
        check("model_single_ff", 32'(model_gen(8'h00, 8'hFF, 8'h00)), 32'hFF);
`else
        check("model_single_ff", 32'(model_gen(8'h00, 8'hFF, 8'h00)), 32'h7E);
`endif

        // Blinker, no backpressure
        got_row.delete(); got_pop.delete(); got_eof.delete();
        send_frame(blinker);
        wait_got(5);
        expect_blinker(0);

        // Still-life block
        got_row.delete(); got_pop.delete(); got_eof.delete();
        send_frame(block);
        wait_got(4);
        expect_row(0, 8'h00, 0, 0);
        expect_row(1, 8'h06, 2, 0);
        expect_row(2, 8'h06, 2, 0);
        expect_row(3, 8'h00, 0, 1);

        // Single-row frame
        got_row.delete(); got_pop.delete(); got_eof.delete();
        send_frame(full1);
        wait_got(1);
`ifdef LIFE_TOROIDAL_EN
        expect_row(0, 8'hFF, 8, 1);
`else
        expect_row(0, 8'h7E, 6, 1);
`endif

        // Backpressure: hold out_ready low for 5 cycles after the first out_valid
        got_row.delete(); got_pop.delete(); got_eof.delete();
        fork
            send_frame(blinker);
            begin
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (bus.out_valid) break;
                end
                check("bp_first_valid", 32'(bus.out_valid), 1);
                bus.out_ready = 1'b0;
                repeat (5) begin
                    #4;
                    check("bp_in_ready", 32'(bus.in_ready), 0);
                    check("bp_out_row", 32'(bus.out_row), 0);
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_got(5);
        expect_blinker(0);

        // Beat without sof in IDLE
        got_row.delete(); got_pop.delete(); got_eof.delete();
        send(8'hAA, 0, 0);
        check("nosof_err_pulse", 32'(bus.frame_err), 1);
        idle(4);
        check("nosof_no_output", 32'(got_row.size()), 0);

        // sof after two rows: old frame dropped (its first row already emitted), new frame complete
        send(8'h00, 1, 0);
        send(8'h08, 0, 0);
        send(8'h00, 1, 0);
        check("resof_err_pulse", 32'(bus.frame_err), 1);
        send(8'h08, 0, 0);
        send(8'h08, 0, 0);
        send(8'h08, 0, 0);
        send(8'h00, 0, 1);
        idle(0);
        wait_got(6);
        expect_row(0, 8'h00, 0, 0);
        expect_blinker(1);

        // Reset mid-frame
        got_row.delete(); got_pop.delete(); got_eof.delete();
        send(8'h00, 1, 0);
        send(8'h08, 0, 0);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 0);
        check("midrst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        got_row.delete(); got_pop.delete(); got_eof.delete();
        send_frame(blinker);
        wait_got(5);
        expect_blinker(0);

        // Random frames with backpressure, gaps and protocol errors
        rand_bp = 1;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 9) == 0) send(W'($urandom), 0, $urandom_range(0, 1) == 1);
            len = $urandom_range(1, 6);
            rows.delete();
            for (int i = 0; i < len; i++) rows.push_back(W'($urandom));
            for (int i = 0; i < len; i++) begin
                send(rows[i], (i == 0) || ($urandom_range(0, 14) == 0), i == len - 1);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            idle($urandom_range(0, 2));
        end
        rand_bp = 0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(negedge clk);
        check("final_drain", 32'(exp_q.size()), 0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
